// File: rtl/pe_rs_stream_if.sv
// Stream/config bundle for the row-stationary PE.
// slave  : the PE side (consumes cfg/filter/ifmap/psum_in, produces psum_out).
// master : the environment side driving the PE.
interface pe_rs_stream_if #(
    parameter int DATA_WIDTH    = 16,
    parameter int PSUM_WIDTH    = 32,
    parameter int RF_ADDR_WIDTH = 3,
    parameter int WIN_WIDTH     = 8
) ();
    logic                          cfg_valid;
    logic [RF_ADDR_WIDTH:0]        cfg_filter_size;
    logic [WIN_WIDTH-1:0]          cfg_num_windows;
    logic                          cfg_acc_psum;
    logic                          busy;
    logic                          filter_valid;
    logic                          filter_ready;
    logic signed [DATA_WIDTH-1:0]  filter;
    logic                          ifmap_valid;
    logic                          ifmap_ready;
    logic signed [DATA_WIDTH-1:0]  ifmap;
    logic                          psum_in_valid;
    logic                          psum_in_ready;
    logic signed [PSUM_WIDTH-1:0]  psum_in;
    logic                          psum_out_valid;
    logic                          psum_out_ready;
    logic signed [PSUM_WIDTH-1:0]  psum_out;

    modport slave (
        input  cfg_valid, cfg_filter_size, cfg_num_windows, cfg_acc_psum,
        input  filter_valid, filter, ifmap_valid, ifmap,
        input  psum_in_valid, psum_in, psum_out_ready,
        output busy, filter_ready, ifmap_ready, psum_in_ready,
        output psum_out_valid, psum_out
    );

    modport master (
        output cfg_valid, cfg_filter_size, cfg_num_windows, cfg_acc_psum,
        output filter_valid, filter, ifmap_valid, ifmap,
        output psum_in_valid, psum_in, psum_out_ready,
        input  busy, filter_ready, ifmap_ready, psum_in_ready,
        input  psum_out_valid, psum_out
    );
endinterface

// File: rtl/pe_rs_stream.sv
// Row-stationary PE: resident filter row, circular ifmap RF, one psum per
// window, optional add of the neighbouring PE's psum before output.
// Optional feature macro: PE_SATURATE_EN (saturating accumulator adds;
// undefined = two's-complement wrap).
module pe_rs_stream #(
    parameter int DATA_WIDTH    = 16,
    parameter int PSUM_WIDTH    = 32,
    parameter int RF_ADDR_WIDTH = 3,
    parameter int WIN_WIDTH     = 8
) (
    input  logic              clk,
    input  logic              rstb,
    pe_rs_stream_if.slave     bus
);
    localparam int DEPTH = 2**RF_ADDR_WIDTH;
    localparam int SW    = RF_ADDR_WIDTH + 1;
    localparam int PW    = 2 * DATA_WIDTH;

    typedef enum logic [2:0] {IDLE, LOAD, MAC, ACC, OUT} state_t;

    state_t                        state_q, state_d;
    logic [SW-1:0]                 s_q, s_d;
    logic [WIN_WIDTH-1:0]          w_q, w_d;
    logic                          accp_q, accp_d;
    logic [WIN_WIDTH-1:0]          win_q, win_d;
    logic [RF_ADDR_WIDTH-1:0]      head_q, head_d;
    logic [RF_ADDR_WIDTH-1:0]      wr_ptr_q, wr_ptr_d;
    logic                          floaded_q, floaded_d;
    logic [SW-1:0]                 fcnt_q, fcnt_d;
    logic [SW-1:0]                 pend_q, pend_d;
    logic [SW-1:0]                 mac_i_q, mac_i_d;
    logic signed [PSUM_WIDTH-1:0]  acc_q, acc_d;
    logic                          busy_q, busy_d;
    logic                          filter_ready_q, filter_ready_d;
    logic                          ifmap_ready_q, ifmap_ready_d;
    logic                          psum_in_ready_q, psum_in_ready_d;
    logic                          psum_out_valid_q, psum_out_valid_d;
    logic signed [DATA_WIDTH-1:0]  filt_q [DEPTH];
    logic signed [DATA_WIDTH-1:0]  filt_d [DEPTH];
    logic signed [DATA_WIDTH-1:0]  ifm_q  [DEPTH];
    logic signed [DATA_WIDTH-1:0]  ifm_d  [DEPTH];

    logic                          f_hs, i_hs, p_hs, o_hs;
    logic [RF_ADDR_WIDTH-1:0]      rd_addr;
    logic signed [DATA_WIDTH-1:0]  f_sel, i_sel;
    logic signed [PW-1:0]          prod;
    logic signed [PSUM_WIDTH-1:0]  prod_ext;
    logic [SW-1:0]                 s_eff;

    // Accumulator adder: saturating or wrapping depending on build
    function automatic logic signed [PSUM_WIDTH-1:0] acc_add(
        input logic signed [PSUM_WIDTH-1:0] a,
        input logic signed [PSUM_WIDTH-1:0] b
    );
`ifdef PE_SATURATE_EN
        logic signed [PSUM_WIDTH:0] s;
        s = (PSUM_WIDTH+1)'(a) + (PSUM_WIDTH+1)'(b);
        if (s[PSUM_WIDTH] != s[PSUM_WIDTH-1])
            return s[PSUM_WIDTH] ? {1'b1, {(PSUM_WIDTH-1){1'b0}}}
                                 : {1'b0, {(PSUM_WIDTH-1){1'b1}}};
        return s[PSUM_WIDTH-1:0];
`else
        return a + b;
`endif
    endfunction

    // Next-state, datapath and registered-output decode
    always_comb begin
        state_d  = state_q;
        s_d      = s_q;
        w_d      = w_q;
        accp_d   = accp_q;
        win_d    = win_q;
        head_d   = head_q;
        wr_ptr_d = wr_ptr_q;
        floaded_d = floaded_q;
        fcnt_d   = fcnt_q;
        pend_d   = pend_q;
        mac_i_d  = mac_i_q;
        acc_d    = acc_q;
        filt_d   = filt_q;
        ifm_d    = ifm_q;

        f_hs = bus.filter_valid   & filter_ready_q;
        i_hs = bus.ifmap_valid    & ifmap_ready_q;
        p_hs = bus.psum_in_valid  & psum_in_ready_q;
        o_hs = bus.psum_out_ready & psum_out_valid_q;

        // MAC operand fetch: filter tap i against ifmap at head+i (wraps mod DEPTH)
        rd_addr  = head_q + mac_i_q[RF_ADDR_WIDTH-1:0];
        f_sel    = filt_q[mac_i_q[RF_ADDR_WIDTH-1:0]];
        i_sel    = ifm_q[rd_addr];
        prod     = PW'(f_sel) * PW'(i_sel);
        prod_ext = PSUM_WIDTH'(prod);

        // Filter length: 0 behaves as 1, anything beyond the RF depth clamps
        if (bus.cfg_filter_size == '0)
            s_eff = SW'(1);
        else if (bus.cfg_filter_size > SW'(DEPTH))
            s_eff = SW'(DEPTH);
        else
            s_eff = bus.cfg_filter_size;

        case (state_q)
            IDLE: begin
                if (bus.cfg_valid) begin
                    s_d       = s_eff;
                    w_d       = (bus.cfg_num_windows == '0) ? WIN_WIDTH'(1) : bus.cfg_num_windows;
                    accp_d    = bus.cfg_acc_psum;
                    win_d     = '0;
                    head_d    = '0;
                    wr_ptr_d  = '0;
                    floaded_d = 1'b0;
                    fcnt_d    = '0;
                    pend_d    = s_eff;
                    state_d   = LOAD;
                end
            end
            LOAD: begin
                if (f_hs) begin
                    filt_d[fcnt_q[RF_ADDR_WIDTH-1:0]] = bus.filter;
                    fcnt_d = fcnt_q + SW'(1);
                end
                if (i_hs) begin
                    ifm_d[wr_ptr_q] = bus.ifmap;
                    wr_ptr_d = wr_ptr_q + RF_ADDR_WIDTH'(1);
                    pend_d   = pend_q - SW'(1);
                end
                if ((floaded_q || fcnt_d == s_q) && pend_d == '0) begin
                    floaded_d = 1'b1;
                    mac_i_d   = '0;
                    state_d   = MAC;
                end
            end
            MAC: begin
                acc_d   = acc_add((mac_i_q == '0) ? '0 : acc_q, prod_ext);
                mac_i_d = mac_i_q + SW'(1);
                if (mac_i_q == s_q - SW'(1))
                    state_d = accp_q ? ACC : OUT;
            end
            ACC: begin
                if (p_hs) begin
                    acc_d   = acc_add(acc_q, bus.psum_in);
                    state_d = OUT;
                end
            end
            OUT: begin
                if (o_hs) begin
                    win_d  = win_q + WIN_WIDTH'(1);
                    head_d = head_q + RF_ADDR_WIDTH'(1);
                    if (win_d == w_q) begin
                        floaded_d = 1'b0;
                        state_d   = IDLE;
                    end else begin
                        pend_d  = SW'(1);
                        state_d = LOAD;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        busy_d           = (state_d != IDLE);
        filter_ready_d   = (state_d == LOAD) && !floaded_d && (fcnt_d < s_d);
        ifmap_ready_d    = (state_d == LOAD) && (pend_d != '0);
        psum_in_ready_d  = (state_d == ACC);
        psum_out_valid_d = (state_d == OUT);
    end

    // Control state and registered outputs; async reset aborts any computation
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            state_q          <= IDLE;
            s_q              <= '0;
            w_q              <= '0;
            accp_q           <= 1'b0;
            win_q            <= '0;
            head_q           <= '0;
            wr_ptr_q         <= '0;
            floaded_q        <= 1'b0;
            fcnt_q           <= '0;
            pend_q           <= '0;
            mac_i_q          <= '0;
            acc_q            <= '0;
            busy_q           <= 1'b0;
            filter_ready_q   <= 1'b0;
            ifmap_ready_q    <= 1'b0;
            psum_in_ready_q  <= 1'b0;
            psum_out_valid_q <= 1'b0;
        end else begin
            state_q          <= state_d;
            s_q              <= s_d;
            w_q              <= w_d;
            accp_q           <= accp_d;
            win_q            <= win_d;
            head_q           <= head_d;
            wr_ptr_q         <= wr_ptr_d;
            floaded_q        <= floaded_d;
            fcnt_q           <= fcnt_d;
            pend_q           <= pend_d;
            mac_i_q          <= mac_i_d;
            acc_q            <= acc_d;
            busy_q           <= busy_d;
            filter_ready_q   <= filter_ready_d;
            ifmap_ready_q    <= ifmap_ready_d;
            psum_in_ready_q  <= psum_in_ready_d;
            psum_out_valid_q <= psum_out_valid_d;
        end
    end

    // Filter and ifmap register files (contents are don't-care until loaded)
    always_ff @(posedge clk) begin
        filt_q <= filt_d;
        ifm_q  <= ifm_d;
    end

    assign bus.busy           = busy_q;
    assign bus.filter_ready   = filter_ready_q;
    assign bus.ifmap_ready    = ifmap_ready_q;
    assign bus.psum_in_ready  = psum_in_ready_q;
    assign bus.psum_out_valid = psum_out_valid_q;
    assign bus.psum_out       = acc_q;
endmodule

// File: doc/pe_rs_stream.md
# pe_rs_stream

Second-generation row-stationary processing element for the neural-processor PE array. It keeps a filter row resident, slides an ifmap window through a circular register file and produces one wide partial sum per window. It can optionally add a partial sum from the neighbouring PE before output. All data movement uses valid/ready handshakes, so the PE can sit behind multicast controllers and FIFOs that stall.

## Interface
- DATA_WIDTH, 16, signed ifmap and filter word width
- PSUM_WIDTH, 32, signed psum width; must be ≥ 2*DATA_WIDTH
- RF_ADDR_WIDTH, 3, register-file address width; DEPTH = 2**RF_ADDR_WIDTH entries per RF
- WIN_WIDTH, 8, width of the window-count configuration

- clk  in  1  clock
- rstb  in  1  asynchronous, active-low reset
- cfg_valid  in  1  configuration strobe; accepted only in IDLE
- cfg_filter_size  in  RF_ADDR_WIDTH+1  filter length S
- cfg_num_windows  in  WIN_WIDTH  number of windows W to compute
- cfg_acc_psum  in  1  1 = add psum_in before output
- busy  out  1  high in every state except IDLE
- filter_valid / filter_ready  in / out  1  filter handshake
- filter  in  DATA_WIDTH  signed filter word
- ifmap_valid / ifmap_ready  in / out  1  ifmap handshake
- ifmap  in  DATA_WIDTH  signed ifmap word
- psum_in_valid / psum_in_ready  in / out  1  upstream psum handshake
- psum_in  in  PSUM_WIDTH  signed upstream psum
- psum_out_valid / psum_out_ready  out / in  1  result handshake
- psum_out  out  PSUM_WIDTH  signed result

## Operation
- States: IDLE, LOAD, MAC, ACC, OUT.
- **IDLE**
  - On cfg_valid, latch S, W and acc_psum. Clear the window counter, head pointer, ifmap write pointer and filter-loaded flag. Go to LOAD.
  - S = 0 means S = 1. S > DEPTH clamps to DEPTH. W = 0 means W = 1.
- **LOAD**
  - filter_ready is high while the filter-loaded flag is 0 and fewer than S filters have been accepted. Filters are stored at indices 0..S-1.
  - ifmap_ready is high while the pending-ifmap count is nonzero. The pending count is S for the first window and 1 for each later window.
  - Ifmaps are written at wr_ptr, which increments mod DEPTH.
  - The two streams are independent, and both may handshake in the same cycle.
  - Go to MAC once both requirements are met. The filter-loaded flag is then set.
- **MAC**
  - Runs exactly S cycles. Cycle i: acc ← (i==0 ? 0 : acc) + filter[i]*ifmap[(head+i) mod DEPTH].
  - The product is the full 2*DATA_WIDTH signed result, sign-extended to PSUM_WIDTH.
  - Next state is ACC if acc_psum = 1, otherwise OUT.
- **ACC**
  - psum_in_ready is high. Wait for psum_in_valid.
  - On the handshake cycle, acc ← acc + psum_in, then go to OUT.
- **OUT**
  - psum_out_valid is high and psum_out = acc; both are held stable until psum_out_ready.
  - On the handshake: window counter++, head ← head+1 mod DEPTH.
  - If the counter equals W, clear the filter-loaded flag and go to IDLE. Otherwise go to LOAD.
- Each ready/valid output is high only in its own state. All outputs are functions of registers only; there are no combinational input-to-output paths.
- cfg_valid outside IDLE is ignored.
- Async reset mid-operation aborts the computation. The resident filter is discarded.
- Output reset values: busy 0, every *_ready 0, psum_out_valid 0, psum_out 0.

## Timing
- A handshake occurs on a rising clk edge when valid and ready are both high.
- cfg accepted at edge T → busy = 1 and LOAD active from T+1.
- Final load handshake at edge L → MAC occupies cycles L+1..L+S.
  - acc_psum = 0: psum_out_valid is high from L+S+1.
  - acc_psum = 1: psum_in_ready is high from L+S+1; psum_out_valid is high the cycle after the psum_in handshake.
- Output handshake at edge O → next state (LOAD or IDLE) is active from O+1. ifmap_ready can therefore be high from O+1.
- Steady-state throughput with no stalls and acc_psum = 0: one psum per S+2 cycles.

## Configuration
- PE_SATURATE_EN defined: every accumulator addition (MAC and ACC) saturates to [-2^(PSUM_WIDTH-1), 2^(PSUM_WIDTH-1)-1].
- PE_SATURATE_EN undefined: additions wrap in two's complement.

## Test plan
- **Single window:** S=3, W=1, acc_psum=0; filters 1,2,3; ifmaps 4,5,6 → psum_out = 32. psum_out_valid rises S+1 = 4 cycles after the last load handshake. busy returns to 0 after the output handshake.
- **Sliding window:** same as the single-window case with W=2 and a second-window ifmap of 7 → outputs 32, then 38. Exactly one ifmap and zero filters are accepted for window 2.
- **Upstream accumulate:** acc_psum=1, data as in the single-window case, psum_in=100 presented 5 cycles late → psum_out = 132. psum_in_ready is high only in ACC, and psum_out_valid is low until the cycle after the psum_in handshake.
- **Backpressure:** psum_out_ready held low for 4 cycles → psum_out_valid and psum_out stay stable. ifmap_ready and filter_ready stay 0. cfg_valid pulsed during the stall is ignored.
- **Overflow:** S=8, all filters and ifmaps = -32768 → psum_out = 2147483647 with PE_SATURATE_EN defined, 0 without it.
- **Reset mid-MAC:** rstb asserted during MAC → all outputs take reset values immediately. A new cfg must re-request S filters and S ifmaps.
